// File: rtl/mips_pkg.sv
// Shared types and helpers for the CPU-side memory bridge.
// Size codes, bridge states, and lane/alignment helpers.
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } bridge_state_e;

  // Reserved size 2'b11 behaves as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    if (size == SZ_BYTE)      return 1'b0;
    else if (size == SZ_HALF) return lane[0];
    else                      return (lane != 2'b00);
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
    if (size == SZ_BYTE)      return 4'b0001 << lane;
    else if (size == SZ_HALF) return 4'b0011 << lane;
    else                      return 4'b1111;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
    if (size == SZ_BYTE)      return {4{data[7:0]}};
    else if (size == SZ_HALF) return {2{data[15:0]}};
    else                      return data;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a 32-bit bus word for sub-word loads.
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = rdata[{lane[1], 4'b0000} +: 16];
    result   = rdata;
    if (size == SZ_BYTE)
      result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
    else if (size == SZ_HALF)
      result = {{16{sign_ext & half_sel[15]}}, half_sel};
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Runs CPU load/store requests on an Avalon-style bus with waitrequest,
// stalling the multicycle controller until the access completes or times out.
module mem_bus_bridge
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        bus_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  // state | meaning
  // IDLE  | waiting for cpu_req; misaligned requests skip the bus
  // BUS   | strobe held, waiting for waitrequest low or timeout
  // RESP  | one-cycle completion strobe, stall released

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bridge_state_e    state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [31:0]      ext_data;

  load_extend u_load_extend (
    .rdata    (avm_readdata),
    .lane     (lane_q),
    .size     (size_q),
    .sign_ext (signed_q),
    .result   (ext_data)
  );

  assign stall = ((state == IDLE) && cpu_req) || (state == BUS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      lane_q         <= '0;
      size_q         <= '0;
      signed_q       <= 1'b0;
      cpu_rdata      <= '0;
      cpu_rvalid     <= 1'b0;
      bus_err        <= 1'b0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (is_misaligned(cpu_size, cpu_addr[1:0])) begin
              bus_err    <= 1'b1;
              cpu_rdata  <= '0;
              cpu_rvalid <= 1'b1;
              state      <= RESP;
            end else begin
              avm_address    <= {cpu_addr[31:2], 2'b00};
              avm_read       <= ~cpu_we;
              avm_write      <= cpu_we;
              avm_byteenable <= lane_enable(cpu_size, cpu_addr[1:0]);
              avm_writedata  <= lane_replicate(cpu_size, cpu_wdata);
              lane_q         <= cpu_addr[1:0];
              size_q         <= cpu_size;
              signed_q       <= cpu_signed;
              wait_cnt       <= '0;
              state          <= BUS;
            end
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            cpu_rdata  <= avm_read ? ext_data : '0;
            cpu_rvalid <= 1'b1;
            state      <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            bus_err    <= 1'b1;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: directed cases plus randomized
// transactions checked against a behavioural model of the bridge.
module tb_mem_bus_bridge;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_signed;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        bus_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  always #5 clk = ~clk;

  mem_bus_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_size        (cpu_size),
    .cpu_signed      (cpu_signed),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .stall           (stall),
    .cpu_rdata       (cpu_rdata),
    .cpu_rvalid      (cpu_rvalid),
    .bus_err         (bus_err),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
  );

  int   n_vec = 0;
  int   n_err = 0;
  logic err_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: little-endian lanes, plain arithmetic.
  function automatic logic m_misaligned(input int size, input int lane);
    if (size == 0) return 1'b0;
    if (size == 1) return (lane % 2) != 0;
    return lane != 0;
  endfunction

  function automatic logic [31:0] m_be(input int size, input int lane);
    if (size == 0) return 32'(1 << lane);
    if (size == 1) return 32'(3 << lane);
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input int size, input logic [31:0] w);
    if (size == 0) return (w & 32'hFF) * 32'h01010101;
    if (size == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int size, input int lane, input bit sgn,
                                         input logic [31:0] rd);
    logic [31:0] v;
    if (size == 0) begin
      v = (rd >> (8 * lane)) & 32'hFF;
      if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (size == 1) begin
      v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic run_txn(input bit we, input int size, input bit sgn, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wcount, input logic [31:0] rd,
                         input bit drop_req);
    int          lane;
    int          exp_bus;
    int          bus_seen;
    int          cyc;
    bit          done;
    bit          err_path;
    logic [31:0] exp_rd;
    lane     = int'(addr[1:0]);
    bus_seen = 0;
    cyc      = 0;
    done     = 0;
    err_path = 0;
    if (m_misaligned(size, lane)) begin
      exp_bus = 0; exp_rd = 0; err_path = 1;
    end else if (wcount >= TIMEOUT) begin
      exp_bus = TIMEOUT; exp_rd = 0; err_path = 1;
    end else begin
      exp_bus = wcount + 1;
      exp_rd  = m_load(size, lane, sgn, rd);
    end
    if (err_path) err_exp = 1'b1;

    cpu_req = 1'b1; cpu_we = we; cpu_size = 2'(size); cpu_signed = sgn;
    cpu_addr = addr; cpu_wdata = wdata;
    avm_readdata = rd; avm_waitrequest = 1'b1;
    #1 check("stall_on_req", 32'(stall), 32'd1);

    while (!done && cyc < TIMEOUT + 6) begin
      @(negedge clk);
      cyc++;
      if (cpu_rvalid) begin
        done = 1;
        check("latency", 32'(cyc), 32'(exp_bus + 1));
        check("bus_cycles", 32'(bus_seen), 32'(exp_bus));
        check("stall_resp", 32'(stall), 32'd0);
        check("bus_err", 32'(bus_err), 32'(err_exp));
        if (!we || err_path) check("rdata", cpu_rdata, exp_rd);
        cpu_req = 1'b0;
      end else if (avm_read || avm_write) begin
        check("strobe", {30'd0, avm_read, avm_write}, {30'd0, ~we, we});
        check("address", avm_address, addr & 32'hFFFFFFFC);
        check("byteenable", 32'(avm_byteenable), m_be(size, lane));
        if (we) check("writedata", avm_writedata, m_wdata(size, wdata));
        check("stall_bus", 32'(stall), 32'd1);
        avm_waitrequest = (bus_seen < wcount);
        bus_seen++;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cpu_size  = 2'($urandom);
        if (drop_req) cpu_req = 1'b0;
      end
    end
    check("rvalid_seen", 32'(done), 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    check("rvalid_once", 32'(cpu_rvalid), 32'd0);
    check("idle_no_strobe", {30'd0, avm_read, avm_write}, 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    check("rst_addr", avm_address, 32'd0);
    check("rst_be", 32'(avm_byteenable), 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    check("rst_stall", 32'(stall), 32'(cpu_req));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    #1 check_reset_values();
    err_exp = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0; cpu_signed = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; avm_waitrequest = 1'b0; avm_readdata = '0;
    #2 reset = 1'b1;
    #1 check_reset_values();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_txn(0, 2, 0, 32'h0000_1000, 32'h0, 0, 32'hDEADBEEF, 0);
    run_txn(0, 0, 1, 32'h0000_1003, 32'h0, 0, 32'h80112233, 0);
    run_txn(0, 0, 0, 32'h0000_1003, 32'h0, 0, 32'h80112233, 0);
    run_txn(1, 0, 0, 32'h0000_2002, 32'h0000_00A5, 3, 32'h0, 0);
    run_txn(0, 1, 1, 32'h0000_1002, 32'h0, 1, 32'h8001_7FFF, 1);
    run_txn(1, 1, 0, 32'h0000_1002, 32'h1234_BEEF, 2, 32'h0, 0);
    run_txn(0, 3, 0, 32'h0000_1004, 32'h0, 0, 32'hCAFEF00D, 0);
    run_txn(0, 2, 0, 32'h0000_3001, 32'h0, 0, 32'h1111_1111, 0);
    run_txn(0, 1, 0, 32'h0000_1002, 32'h0, 0, 32'h0000_4321, 0);
    do_reset();
    run_txn(0, 2, 0, 32'h0000_5000, 32'h0, TIMEOUT + 4, 32'h5555_AAAA, 0);
    run_txn(0, 1, 0, 32'h0000_5001, 32'h0, 0, 32'h0, 0);
    do_reset();

    // Reset during the second BUS cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h0000_4000;
    avm_waitrequest = 1'b1; avm_readdata = 32'h7777_7777;
    @(negedge clk);
    check("rstmid_bus0", 32'(avm_read), 32'd1);
    @(negedge clk);
    check("rstmid_bus1", 32'(avm_read), 32'd1);
    reset = 1'b1; cpu_req = 1'b0;
    #1 check("rstmid_read_drop", 32'(avm_read), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    err_exp = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_no_rvalid", 32'(cpu_rvalid), 32'd0);
    end
    run_txn(0, 2, 0, 32'h0000_4000, 32'h0, 1, 32'h0BAD_F00D, 0);

    // Randomized transactions
    for (int i = 0; i < 80; i++) begin
      bit          we;
      int          size;
      logic [31:0] addr;
      int          wc;
      if (i == 40) do_reset();
      we   = 1'($urandom);
      size = int'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (size == 1) addr[0] = 1'b0;
        else if (size >= 2) addr[1:0] = 2'b00;
      end
      wc = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, 4));
      run_txn(we, size, 1'($urandom), addr, $urandom, wc, $urandom, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
